// File: rtl/pwm_duty_ctrl_if.sv
// Switch/tick inputs and slew-limited duty outputs of pwm_duty_ctrl.
// The master side drives the switches and period tick; the slave side is the controller.
interface pwm_duty_ctrl_if;
    logic [3:0] sw_raw;
    logic       period_tick;
    logic [3:0] duty_code;
    logic [3:0] target;
    logic       ramping;
    logic       update;

    modport master (
        output sw_raw,
        output period_tick,
        input  duty_code,
        input  target,
        input  ramping,
        input  update
    );

    modport slave (
        input  sw_raw,
        input  period_tick,
        output duty_code,
        output target,
        output ramping,
        output update
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Debounces a 4-bit switch vector and slews the PWM duty code toward it,
// one LSB per STEP_PERIODS period ticks, changing only on period boundaries.
module pwm_duty_ctrl #(
    parameter int DEB_CYCLES   = 16,
    parameter int STEP_PERIODS = 4
) (
    input  logic           clk,
    input  logic           rst,
    pwm_duty_ctrl_if.slave bus
);
    localparam int             CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  DEB_MAX  = CW'(DEB_CYCLES - 1);
    localparam logic [7:0]     STEP_MAX = 8'(STEP_PERIODS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    cand_r;
    logic [CW-1:0] deb_cnt_r;
    logic [3:0]    target_r;
    logic [3:0]    duty_r;
    logic [7:0]    tick_r;
    logic [1:0]    state_r;
    logic          update_r;
    logic [1:0]    state_s;
    logic          reversal_s;

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'd0;
            sync2_r <= 4'd0;
        end else begin
            sync1_r <= bus.sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Whole-vector debounce: any change restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r    <= 4'd0;
            deb_cnt_r <= '0;
            target_r  <= 4'd0;
        end else if (sync2_r != cand_r) begin
            cand_r    <= sync2_r;
            deb_cnt_r <= '0;
        end else if (deb_cnt_r != DEB_MAX) begin
            deb_cnt_r <= deb_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            target_r  <= cand_r;
        end
    end

    // Slew direction from registered duty/target; a reversal is an UP<->DOWN flip.
    always_comb begin
        state_s    = ST_IDLE;
        reversal_s = 1'b0;
        if (duty_r == target_r) begin
            state_s = ST_IDLE;
        end else if (duty_r < target_r) begin
            state_s = ST_UP;
        end else begin
            state_s = ST_DOWN;
        end
        if ((state_r != ST_IDLE) && (state_s != ST_IDLE) && (state_r != state_s)) begin
            reversal_s = 1'b1;
        end else begin
            reversal_s = 1'b0;
        end
    end

    // Tick counting and one-LSB stepping; the step sees the pre-edge target so it cannot overshoot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r   <= 4'd0;
            tick_r   <= 8'd0;
            state_r  <= ST_IDLE;
            update_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            update_r <= 1'b0;
            case (state_s)
                ST_IDLE: begin
                    tick_r <= 8'd0;
                end
                ST_UP, ST_DOWN: begin
                    if (reversal_s) begin
                        tick_r <= 8'd0;
                    end else if (bus.period_tick) begin
                        if (tick_r == STEP_MAX) begin
                            tick_r   <= 8'd0;
                            update_r <= 1'b1;
                            duty_r   <= (state_s == ST_UP) ? duty_r + 4'd1 : duty_r - 4'd1;
                        end else begin
                            tick_r <= tick_r + 8'd1;
                        end
                    end else begin
                        tick_r <= tick_r;
                    end
                end
                default: begin
                    tick_r <= 8'd0;
                end
            endcase
        end
    end

    assign bus.duty_code = duty_r;
    assign bus.target    = target_r;
    assign bus.ramping   = (duty_r != target_r);
    assign bus.update    = update_r;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with DEB_CYCLES=4, STEP_PERIODS=2 and a period tick every 8 cycles.
module tb_pwm_duty_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   ph;
    bit   tick_en;

    pwm_duty_ctrl_if bif();

    pwm_duty_ctrl #(.DEB_CYCLES(4), .STEP_PERIODS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick_cycle();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 8;
        bif.period_tick = tick_en && (ph == 0);
    endtask

    task automatic wait_target(input logic [3:0] val, input int budget, output bit ok);
        ok = (bif.target === val);
        for (int i = 0; i < budget && !ok; i++) begin
            tick_cycle();
            ok = (bif.target === val);
        end
    endtask

    task automatic wait_step(input logic [3:0] val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick_cycle();
            ok = (bif.update === 1'b1) && (bif.duty_code === val);
        end
    endtask

    // Runs until ramping drops, collecting step statistics; a bad step is a non +/-1 change,
    // a change without update or without a tick on the previous cycle, or a spurious update.
    task automatic settle(input int budget, output int n_upd, output int n_ticks, output int n_bad,
                          output int dmax, output int dmin, output bit done, output bit fin_upd);
        int prev;
        bit prev_tick;
        prev = int'(bif.duty_code);
        n_upd = 0; n_ticks = 0; n_bad = 0; dmax = prev; dmin = prev;
        done = !bif.ramping; fin_upd = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (bif.period_tick && bif.ramping) n_ticks++;
            prev_tick = bif.period_tick;
            tick_cycle();
            if (bif.update) n_upd++;
            if (int'(bif.duty_code) != prev) begin
                if (!bif.update || !prev_tick ||
                    (int'(bif.duty_code) != prev + 1 && int'(bif.duty_code) != prev - 1)) n_bad++;
            end else if (bif.update) begin
                n_bad++;
            end
            if (int'(bif.duty_code) > dmax) dmax = int'(bif.duty_code);
            if (int'(bif.duty_code) < dmin) dmin = int'(bif.duty_code);
            prev = int'(bif.duty_code);
            done = !bif.ramping;
            fin_upd = bif.update;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick_cycle();
        total++; if (bif.duty_code !== 4'd0) $display("FAIL rst_duty: got %0d expected 0", bif.duty_code); else passed++;
        total++; if (bif.target !== 4'd0) $display("FAIL rst_target: got %0d expected 0", bif.target); else passed++;
        total++; if (bif.ramping !== 1'b0) $display("FAIL rst_ramping: got %0b expected 0", bif.ramping); else passed++;
        total++; if (bif.update !== 1'b0) $display("FAIL rst_update: got %0b expected 0", bif.update); else passed++;
        rst = 1'b0;
        tick_en = 1'b1;
        repeat (3) tick_cycle();
        total++; if (bif.duty_code !== 4'd0) $display("FAIL post_rst_duty: got %0d expected 0", bif.duty_code); else passed++;
    endtask

    task automatic test_glitch();
        int n_tgt, n_upd, n_ramp;
        n_tgt = 0; n_upd = 0; n_ramp = 0;
        bif.sw_raw = 4'd5;
        for (int i = 0; i < 23; i++) begin
            tick_cycle();
            if (i == 2) bif.sw_raw = 4'd0;
            if (bif.target !== 4'd0) n_tgt++;
            if (bif.update !== 1'b0) n_upd++;
            if (bif.ramping !== 1'b0) n_ramp++;
        end
        total++; if (n_tgt != 0) $display("FAIL glitch_target: got %0d nonzero cycles expected 0", n_tgt); else passed++;
        total++; if (n_upd != 0) $display("FAIL glitch_update: got %0d pulses expected 0", n_upd); else passed++;
        total++; if (n_ramp != 0) $display("FAIL glitch_ramping: got %0d cycles expected 0", n_ramp); else passed++;
    endtask

    task automatic test_ramp_up();
        int n_upd, n_ticks, n_bad, dmax, dmin;
        bit done, fin_upd;
        bif.sw_raw = 4'd3;
        repeat (6) tick_cycle();
        total++; if (bif.target !== 4'd0) $display("FAIL up_target_early: got %0d expected 0", bif.target); else passed++;
        tick_cycle();
        total++; if (bif.target !== 4'd3) $display("FAIL up_target_latency: got %0d expected 3", bif.target); else passed++;
        total++; if (bif.ramping !== 1'b1) $display("FAIL up_ramping: got %0b expected 1", bif.ramping); else passed++;
        settle(400, n_upd, n_ticks, n_bad, dmax, dmin, done, fin_upd);
        total++; if (!done) $display("FAIL up_timeout: got ramping after 400 cycles expected settled"); else passed++;
        total++; if (bif.duty_code !== 4'd3) $display("FAIL up_duty: got %0d expected 3", bif.duty_code); else passed++;
        total++; if (n_upd != 3) $display("FAIL up_updates: got %0d expected 3", n_upd); else passed++;
        total++; if (n_ticks != 6) $display("FAIL up_ticks: got %0d expected 6", n_ticks); else passed++;
        total++; if (n_bad != 0) $display("FAIL up_bad_steps: got %0d expected 0", n_bad); else passed++;
        total++; if (!fin_upd) $display("FAIL up_last_step: got update 0 when ramping fell expected 1"); else passed++;
    endtask

    task automatic test_ramp_down();
        int n_upd, n_ticks, n_bad, dmax, dmin;
        bit ok, done, fin_upd;
        bif.sw_raw = 4'd15;
        wait_target(4'd15, 20, ok);
        settle(600, n_upd, n_ticks, n_bad, dmax, dmin, done, fin_upd);
        total++; if (bif.duty_code !== 4'd15) $display("FAIL down_reach15: got %0d expected 15", bif.duty_code); else passed++;
        bif.sw_raw = 4'd0;
        wait_target(4'd0, 20, ok);
        total++; if (!ok) $display("FAIL down_target: got %0d expected 0", bif.target); else passed++;
        settle(600, n_upd, n_ticks, n_bad, dmax, dmin, done, fin_upd);
        total++; if (bif.duty_code !== 4'd0) $display("FAIL down_duty: got %0d expected 0", bif.duty_code); else passed++;
        total++; if (n_upd != 15) $display("FAIL down_updates: got %0d expected 15", n_upd); else passed++;
        total++; if (n_ticks != 30) $display("FAIL down_ticks: got %0d expected 30", n_ticks); else passed++;
        total++; if (n_bad != 0) $display("FAIL down_bad_steps: got %0d expected 0", n_bad); else passed++;
        total++; if (dmax != 15) $display("FAIL down_max: got %0d expected 15", dmax); else passed++;
    endtask

    task automatic test_reverse();
        bit ok;
        int dmax, off3, off2;
        bif.sw_raw = 4'd8;
        wait_step(4'd4, 500, ok);
        total++; if (!ok) $display("FAIL rev_reach4: got %0d expected 4", bif.duty_code); else passed++;
        dmax = int'(bif.duty_code); off3 = -1; off2 = -1;
        for (int off = 1; off <= 80; off++) begin
            tick_cycle();
            if (off == 8) bif.sw_raw = 4'd2;
            if (int'(bif.duty_code) > dmax) dmax = int'(bif.duty_code);
            if (bif.update && bif.duty_code == 4'd3 && off3 < 0) off3 = off;
            if (bif.update && bif.duty_code == 4'd2 && off2 < 0) off2 = off;
        end
        total++; if (dmax != 4) $display("FAIL rev_max: got %0d expected 4", dmax); else passed++;
        total++; if (off3 != 32) $display("FAIL rev_step3_cycle: got %0d expected 32", off3); else passed++;
        total++; if (off2 != 48) $display("FAIL rev_step2_cycle: got %0d expected 48", off2); else passed++;
        total++; if (bif.duty_code !== 4'd2 || bif.ramping !== 1'b0)
            $display("FAIL rev_final: got duty %0d ramping %0b expected 2 0", bif.duty_code, bif.ramping); else passed++;
    endtask

    task automatic test_coincident();
        bit ok, done, fin_upd;
        int n_upd, n_ticks, n_bad, dmax, dmin;
        bif.sw_raw = 4'd5;
        wait_step(4'd4, 500, ok);
        total++; if (!ok) $display("FAIL coin_reach4: got %0d expected 4", bif.duty_code); else passed++;
        repeat (9) tick_cycle();
        bif.sw_raw = 4'd1;
        repeat (6) tick_cycle();
        total++; if (bif.duty_code !== 4'd4 || bif.target !== 4'd5)
            $display("FAIL coin_before: got duty %0d target %0d expected 4 5", bif.duty_code, bif.target); else passed++;
        tick_cycle();
        total++; if (bif.duty_code !== 4'd5 || bif.target !== 4'd1 || bif.update !== 1'b1)
            $display("FAIL coin_edge: got duty %0d target %0d update %0b expected 5 1 1",
                     bif.duty_code, bif.target, bif.update); else passed++;
        settle(600, n_upd, n_ticks, n_bad, dmax, dmin, done, fin_upd);
        total++; if (bif.duty_code !== 4'd1) $display("FAIL coin_final: got %0d expected 1", bif.duty_code); else passed++;
        total++; if (n_upd != 4 || n_bad != 0 || dmax != 5)
            $display("FAIL coin_down: got updates %0d bad %0d max %0d expected 4 0 5", n_upd, n_bad, dmax); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok, done, fin_upd;
        int n_upd, n_ticks, n_bad, dmax, dmin;
        bif.sw_raw = 4'd9;
        wait_step(4'd6, 600, ok);
        total++; if (!ok || bif.ramping !== 1'b1)
            $display("FAIL rmid_setup: got duty %0d ramping %0b expected 6 1", bif.duty_code, bif.ramping); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bif.duty_code !== 4'd0 || bif.target !== 4'd0 || bif.ramping !== 1'b0 || bif.update !== 1'b0)
            $display("FAIL rmid_async: got duty %0d target %0d ramping %0b update %0b expected 0 0 0 0",
                     bif.duty_code, bif.target, bif.ramping, bif.update); else passed++;
        bif.sw_raw = 4'd6;
        repeat (2) tick_cycle();
        rst = 1'b0;
        repeat (6) tick_cycle();
        total++; if (bif.target !== 4'd0 || bif.duty_code !== 4'd0)
            $display("FAIL rmid_redebounce: got target %0d duty %0d expected 0 0", bif.target, bif.duty_code); else passed++;
        tick_cycle();
        total++; if (bif.target !== 4'd6) $display("FAIL rmid_target: got %0d expected 6", bif.target); else passed++;
        settle(600, n_upd, n_ticks, n_bad, dmax, dmin, done, fin_upd);
        total++; if (bif.duty_code !== 4'd6 || n_upd != 6 || n_bad != 0 || dmin != 0)
            $display("FAIL rmid_ramp: got duty %0d updates %0d bad %0d min %0d expected 6 6 0 0",
                     bif.duty_code, n_upd, n_bad, dmin); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        ph = 0;
        tick_en = 1'b0;
        rst = 1'b1;
        bif.sw_raw = 4'd0;
        bif.period_tick = 1'b0;
        test_reset();
        test_glitch();
        test_ramp_up();
        test_ramp_down();
        test_reverse();
        test_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
